matrix_product_check: RTL and testbench
=======================================

# matrix_product_check

Checks results from the matrix inverse unit. It accepts an N×N signed fixed-point matrix A, then a candidate inverse B, from a streaming source. It computes C = A·B with a single sequential multiply-accumulate, then streams C out row-major. Alongside the stream it reports whether C is within a tolerance of the identity matrix.

## Interface
- N, default 3: matrix dimension.
- W, default 16: element width, signed Q(W-8).8; default is Q8.8.
- TOL, default 2: maximum allowed |C_ij − I_ij| in LSBs for the identity check.

- clk  in  1  rising-edge clock; sole clock.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  in_data holds a valid element.
- in_ready  out  1  block can accept an element.
- in_data  in  W  element: all of A row-major, then all of B row-major.
- out_valid  out  1  out_data holds a valid C element.
- out_ready  in  1  sink accepts the element.
- out_data  out  W  C element, row-major, saturated.
- out_last  out  1  marks C[N-1][N-1].
- is_identity  out  1  C within TOL of identity; stable while out_valid=1.

## Operation
- States: LOAD → COMPUTE → EMIT → LOAD.
- **LOAD**
  - in_ready=1.
  - On each handshake (in_valid & in_ready), store the element at index cnt and increment cnt.
  - Indices 0..N²−1 fill A; indices N²..2N²−1 fill B.
  - After the handshake at cnt=2N²−1, go to COMPUTE and clear the counters.
- **COMPUTE**
  - in_ready=0 and out_valid=0.
  - Loop over i, j, k, each 0..N−1; one MAC per cycle: acc += A[i][k]·B[k][j].
  - Product width is 2W; accumulator width is 2W+⌈log2 N⌉, signed.
  - On k=N−1, the final sum is scaled: s = (acc + A[i][N−1]·B[N−1][j]) >>> 8 (arithmetic shift, truncation toward −∞).
  - C[i][j] = s saturated to [−2^(W−1), 2^(W−1)−1]. acc then resets to 0.
  - The identity check uses unsaturated s against expected value 256 on the diagonal and 0 off it.
  - An identity accumulator is initialised to 1 on COMPUTE entry and ANDed with (|s − expected| ≤ TOL) per element.
  - Takes exactly N³ cycles, then goes to EMIT.
- **EMIT**
  - out_valid=1; out_data=C[idx]; out_last=(idx==N²−1).
  - is_identity drives the final check result and holds constant through EMIT.
  - On each handshake, idx increments.
  - After the handshake with out_last=1, go to LOAD.
  - out_valid and is_identity drop to 0 the next cycle; in_ready rises the same cycle.
- Inputs arriving while in_ready=0 are ignored; the source must hold them per valid/ready rules.
- Held data: while out_valid=1 and out_ready=0, out_data, out_last and is_identity must not change.

## Timing
- Reset values:
  - While rst_n is low at a clock edge: state=LOAD, every counter and acc = 0.
  - out_valid=0, out_data=0, out_last=0, is_identity=0.
  - in_ready is forced 0 while rst_n=0; it is 1 in the first cycle with rst_n=1.
- Input throughput: one element per cycle; 2N² cycles minimum to load.
- Latency: out_valid asserts exactly N³+1 cycles after the clock edge that accepted the last B element. For N=3 this is 28.
- Output throughput: one element per cycle when out_ready=1. The minimum full transaction is 2N² + N³ + N² cycles; for N=3 this is 54.
- All outputs are registered, except in_ready, which is decoded from state.
- Reset mid-operation: rst_n low in any state aborts the operation and applies the reset values on that edge. Partial A/B contents are discarded, and the next load restarts at A[0][0].
- Simultaneous events:
  - In EMIT, a handshake on the last element moves to LOAD.
  - The source may present in_valid in that same cycle; it is not accepted until in_ready=1 on the following cycle.

## Test plan
- **Identity:** A=I and B=I, using 256 on the diagonal and 0 elsewhere, with out_ready=1 → out_data is the 9 elements 256,0,0,0,256,0,0,0,256. out_last is on the 9th element only. is_identity=1. The first out_valid comes 28 cycles after the last input.
- **Known inverse:** A=diag(512,1024,2048) and B=diag(128,64,32) → C=diag(256,256,256), is_identity=1. A second transaction with B=diag(128,64,33) gives C[2][2]=264 and is_identity=0.
- **Non-identity and tolerance:**
  - A all 256 and B all 256 → all 9 outputs are 768, is_identity=0.
  - With TOL=2, C diagonal values of 258 → is_identity=1.
  - C diagonal values of 259 → is_identity=0.
- **Saturation and sign:**
  - A=diag(32512) and B=diag(32512) → diagonal 32767 (saturated), is_identity=0.
  - A=diag(−32512) and B=diag(32512) → diagonal −32768.
  - A=diag(−1) and B=diag(1) → diagonal −1 (>>> floors toward −∞).
- **Backpressure:** toggle out_ready with a pseudo-random pattern in EMIT → out_data, out_last and is_identity stay stable while stalled. Exactly 9 elements transfer in order, and in_ready stays 0 until after the last handshake.
- **Reset mid-COMPUTE:** drop rst_n for 1 cycle at cycle 10 of COMPUTE → the next cycle shows out_valid=0 and in_ready=1. A fresh identity load then produces the correct results.

Source files
------------

// File: rtl/matrix_product_check.sv
// Verifies a candidate inverse: loads A then B, forms C = A*B with one MAC per cycle,
// streams C row-major and flags whether C lies within TOL LSBs of the Q.8 identity.
module matrix_product_check #(
  parameter int N   = 3,
  parameter int W   = 16,
  parameter int TOL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         is_identity
);
  localparam int NN = N * N;
  localparam int CW = $clog2(2 * NN + 1);
  localparam int IW = $clog2(N + 1);
  localparam int MW = $clog2(NN + 1);
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + $clog2(N);
  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_EMIT} state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_i, r_j, r_k;
  logic [MW-1:0]         r_idx;
  logic signed [AW-1:0]  r_acc;
  logic                  r_id;
  logic signed [W-1:0]   r_a [NN];
  logic signed [W-1:0]   r_b [NN];
  logic signed [W-1:0]   r_c [NN];
  logic                  r_out_valid, r_out_last, r_is_id;
  logic [W-1:0]          r_out_data;

  logic                  w_in_fire, w_out_fire, w_load_done, w_emit_done;
  logic                  w_k_last, w_j_last, w_i_last, w_last_mac;
  logic [MW-1:0]         w_a_idx, w_b_idx, w_c_idx, w_idx_nxt;
  logic signed [W-1:0]   w_a_el, w_b_el;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_sum, w_s, w_exp;
  logic signed [AW:0]    w_diff, w_abs;
  logic                  w_within;
  logic [W-1:0]          w_sat;

  assign in_ready    = rst_n & (r_state == S_LOAD);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign is_identity = r_is_id;

  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_load_done = w_in_fire & (r_cnt == CW'(2 * NN - 1));
  assign w_emit_done = w_out_fire & r_out_last;
  assign w_k_last    = (r_k == IW'(N - 1));
  assign w_j_last    = (r_j == IW'(N - 1));
  assign w_i_last    = (r_i == IW'(N - 1));
  assign w_last_mac  = w_k_last & w_j_last & w_i_last;

  assign w_a_idx   = MW'(int'(r_i) * N + int'(r_k));
  assign w_b_idx   = MW'(int'(r_k) * N + int'(r_j));
  assign w_c_idx   = MW'(int'(r_i) * N + int'(r_j));
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_a_el    = r_a[w_a_idx];
  assign w_b_el    = r_b[w_b_idx];

  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign w_prod = {{W{w_a_el[W-1]}}, w_a_el} * {{W{w_b_el[W-1]}}, w_b_el};
  assign w_sum  = r_acc + AW'(w_prod);
  assign w_s    = w_sum >>> 8;
  assign w_exp  = (r_i == r_j) ? AW'(256) : '0;
  assign w_diff = $signed({w_s[AW-1], w_s}) - $signed({w_exp[AW-1], w_exp});
  assign w_abs  = w_diff[AW] ? -w_diff : w_diff;
  assign w_within = (w_abs <= (AW+1)'(TOL));
  assign w_sat  = (w_s > SMAX) ? SMAX[W-1:0] :
                  (w_s < SMIN) ? SMIN[W-1:0] : w_s[W-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:    if (w_load_done) w_next = S_COMPUTE;
      S_COMPUTE: if (w_last_mac)  w_next = S_EMIT;
      S_EMIT:    if (w_emit_done) w_next = S_LOAD;
      default:   w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      if (r_cnt < CW'(NN)) r_a[MW'(r_cnt)] <= $signed(in_data);
      else                 r_b[MW'(r_cnt - CW'(NN))] <= $signed(in_data);
    end
    if (r_state == S_COMPUTE && w_k_last) r_c[w_c_idx] <= w_sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_id        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_is_id     <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_done) begin
            r_cnt <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
            r_id  <= 1'b1;
          end else if (w_in_fire) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (w_k_last) begin
            r_acc <= '0;
            r_id  <= r_id & w_within;
            r_k   <= '0;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= w_i_last ? '0 : r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
          end
          if (w_last_mac) r_idx <= '0;
        end
        S_EMIT: begin
          // First EMIT cycle registers C[0]; later cycles advance on each handshake.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_c[r_idx];
            r_out_last  <= (r_idx == MW'(NN - 1));
            r_is_id     <= r_id;
          end else if (w_out_fire) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= '0;
              r_is_id     <= 1'b0;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_data <= r_c[w_idx_nxt];
              r_out_last <= (w_idx_nxt == MW'(NN - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_product_check.sv
// Randomized and directed bench for matrix_product_check against an integer-arithmetic
// reference model of C = (A*B) >>> 8 with saturation and identity tolerance.
module tb_matrix_product_check;
  localparam int N   = 3;
  localparam int W   = 16;
  localparam int TOL = 2;
  localparam int NN  = N * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         is_identity;

  int n_cmp = 0;
  int n_err = 0;
  int a_m [NN];
  int b_m [NN];
  int exp_c [NN];
  int exp_id;

  always #5 clk = ~clk;

  matrix_product_check #(.N(N), .W(W), .TOL(TOL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .is_identity(is_identity)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model();
    longint sum, s, d;
    exp_id = 1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += longint'(a_m[i*N+k]) * longint'(b_m[k*N+j]);
        s = sum >>> 8;
        d = s - ((i == j) ? 256 : 0);
        if (d < 0) d = -d;
        if (d > TOL) exp_id = 0;
        exp_c[i*N+j] = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
      end
  endtask

  task automatic set_diag(input int a0, a1, a2, b0, b1, b2);
    for (int x = 0; x < NN; x++) begin a_m[x] = 0; b_m[x] = 0; end
    a_m[0] = a0; a_m[4] = a1; a_m[8] = a2;
    b_m[0] = b0; b_m[4] = b1; b_m[8] = b2;
  endtask

  task automatic set_fill(input int av, input int bv);
    for (int x = 0; x < NN; x++) begin a_m[x] = av; b_m[x] = bv; end
  endtask

  task automatic load_mats(input bit gaps);
    int n, cyc, v;
    bit fire;
    n = 0; cyc = 0;
    while (n < 2 * NN && cyc < 500) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        v = (n < NN) ? a_m[n] : b_m[n - NN];
        in_valid = 1'b1;
        in_data  = W'(v);
      end
      fire = in_valid && in_ready;
      @(posedge clk); #1; cyc++;
      if (fire) n++;
    end
    in_valid = 1'b0;
    chk("load_count", n, 2 * NN);
  endtask

  task automatic run_txn(input bit gaps, input bit bp, input bit junk);
    int cyc, e;
    bit fire, stalled;
    logic [W-1:0] hd;
    logic hl, hi;
    model();
    load_mats(gaps);
    chk("in_ready_compute", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk("latency", cyc, N * N * N + 1);
    e = 0; cyc = 0; stalled = 1'b0;
    hd = '0; hl = 1'b0; hi = 1'b0;
    while (e < NN && cyc < 500) begin
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (junk) begin in_valid = 1'b1; in_data = 16'h7777; end
      if (stalled) begin
        chk("hold_data", out_data, hd);
        chk("hold_last", out_last, hl);
        chk("hold_id", is_identity, hi);
      end
      chk("in_ready_emit", in_ready, 0);
      fire    = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      hd = out_data; hl = out_last; hi = is_identity;
      if (fire) begin
        chk($sformatf("c%0d", e), longint'($signed(out_data)), exp_c[e]);
        chk($sformatf("last%0d", e), out_last, (e == NN - 1));
        chk($sformatf("id%0d", e), is_identity, exp_id);
        e++;
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("emit_count", e, NN);
    chk("post_valid", out_valid, 0);
    chk("post_id", is_identity, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_id", is_identity, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_rel", in_ready, 1);

    set_diag(256, 256, 256, 256, 256, 256);       run_txn(0, 0, 0);
    set_diag(512, 1024, 2048, 128, 64, 32);       run_txn(0, 0, 1);
    set_diag(512, 1024, 2048, 128, 64, 33);       run_txn(0, 0, 0);
    set_fill(256, 256);                           run_txn(1, 0, 0);
    set_diag(256, 256, 256, 258, 258, 258);       run_txn(0, 1, 0);
    set_diag(256, 256, 256, 259, 259, 259);       run_txn(0, 1, 0);
    set_diag(32512, 32512, 32512, 32512, 32512, 32512);    run_txn(0, 0, 0);
    set_diag(-32512, -32512, -32512, 32512, 32512, 32512); run_txn(0, 0, 0);
    set_diag(-1, -1, -1, 1, 1, 1);                run_txn(0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int x = 0; x < NN; x++) begin
        a_m[x] = int'($signed(16'($urandom)));
        b_m[x] = int'($signed(16'($urandom)));
      end
      run_txn(t[0], 1, 1);
    end
    for (int t = 0; t < 6; t++) begin
      set_diag(0, 0, 0, 0, 0, 0);
      for (int x = 0; x < N; x++) begin
        d = $urandom_range(256, 1024);
        a_m[x*N+x] = d;
        b_m[x*N+x] = 65536 / d + $urandom_range(0, 2) - 1;
        a_m[x*N + (x+1) % N] = $urandom_range(0, 1);
      end
      run_txn(t[0], t[1], 1);
    end

    set_diag(256, 256, 256, 256, 256, 256);
    load_mats(0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1);
    run_txn(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
